seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 105 ++++++++++
 tb/tb_seq_divider.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, registered
// quotient/remainder with a one-cycle done pulse and a divide-by-zero flag.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [WIDTH-1:0]      r;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      d;
    logic [CNT_W-1:0]      count;
    logic signed [WIDTH:0] trial;
    logic [WIDTH-1:0]      r_next;
    logic [WIDTH-1:0]      q_next;

    // The shifted remainder can reach 2*D-1, so the trial subtract keeps the carry bit.
    always_comb begin
        trial = $signed({r, q[WIDTH-1]} - {1'b0, d});
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = {r[WIDTH-2:0], q[WIDTH-1]};
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

    // Divisor copy is pure data; it is only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            d <= divisor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r           <= '0;
            q           <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            q     <= dividend;
                            r     <= '0;
                            count <= '0;
                        end
                    end
                end
                RUN: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_STEP) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider (WIDTH=8) against hand values and / % reference.
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] prev_q;
    logic [7:0] prev_r;
    logic       prev_dz;

    seq_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a posedge with the DUT in IDLE; returns just after the DONE->IDLE edge.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit repulse,
                           input string tag);
        logic [7:0] eq, er;
        logic       edz;
        int         cyc, busy_cnt;
        bit         hold_bad, extra;
        if (b == 8'd0) begin eq = 8'hFF; er = a; edz = 1'b1; end
        else begin eq = a / b; er = a % b; edz = 1'b0; end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; busy_cnt = 0; hold_bad = 0;
        if (repulse) begin dividend = ~a; divisor = b + 8'd1; end
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            if (quotient !== prev_q || remainder !== prev_r || div_by_zero !== prev_dz)
                hold_bad = 1;
            start = repulse && (cyc == 3);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, cyc, (b == 8'd0) ? 1 : 9);
        chk({tag, "_busy_cycles"}, busy_cnt, (b == 8'd0) ? 0 : 8);
        chk({tag, "_hold"}, hold_bad, 0);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, edz);
        prev_q = eq; prev_r = er; prev_dz = edz;
        start = repulse;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_pulse"}, done, 0);
        if (repulse) begin
            extra = 0;
            repeat (4) begin
                @(posedge clk); #1;
                if (done || busy) extra = 1;
            end
            chk({tag, "_no_extra"}, extra, 0);
            chk({tag, "_q_after"}, quotient, eq);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        bit         seen;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);
        rst = 1'b0;
        prev_q = '0; prev_r = '0; prev_dz = 1'b0;

        run_div(8'd100, 8'd7, 0, "d100_7");
        run_div(8'd255, 8'd1, 0, "d255_1");
        run_div(8'd5, 8'd9, 0, "d5_9");
        run_div(8'd37, 8'd0, 0, "d37_0");
        run_div(8'd200, 8'd3, 0, "d200_3");
        run_div(8'd255, 8'd200, 0, "d255_200");
        run_div(8'd255, 8'd255, 0, "d255_255");
        run_div(8'd0, 8'd5, 0, "d0_5");
        run_div(8'd254, 8'd255, 0, "d254_255");
        run_div(8'd171, 8'd13, 1, "repulse");

        // Reset during RUN cycle 4 of 100/7.
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_dbz", div_by_zero, 0);
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("midrst_no_done", seen, 0);
        rst = 1'b0;
        prev_q = '0; prev_r = '0; prev_dz = 1'b0;
        run_div(8'd100, 8'd7, 0, "after_rst");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            run_div(ra, rb, 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
